pipe_hazard_ctrl: RTL

Parametrised hazard, forwarding and pipeline-occupancy controller for the in-order integer pipeline, replacing the fixed-depth E/M/W forward and stall logic. It tracks every in-flight register write from execute (stage 0) to writeback (stage STAGES-1) and decides issue stalls, bubble injection and decode flush. It also produces per-source forwarding selects for the instruction in execute, and supports multi-cycle execute ops and configurable load latency. It sits beside the decode stage and drives the fetch/decode stall and flush controls.

---
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and occupancy controller for the in-order integer pipeline.
// Tracks in-flight register writes from execute (stage 0) to writeback (STAGES-1).
module pipe_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int STAGES      = 3,
    parameter int NUM_SRC     = 2,
    parameter int LOAD_READY  = 2,
    parameter bit ZERO_REG_EN = 1'b1,
    localparam int SEL_W      = $clog2(STAGES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid_i,
    input  logic [NUM_SRC*REG_AW-1:0] issue_src_i,
    input  logic [NUM_SRC-1:0]        issue_src_used_i,
    input  logic                      issue_we_i,
    input  logic [REG_AW-1:0]         issue_dst_i,
    input  logic                      issue_load_i,
    input  logic                      redirect_i,
    input  logic                      ex_busy_i,
    output logic                      stall_f_o,
    output logic                      stall_d_o,
    output logic                      flush_d_o,
    output logic                      flush_e_o,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
    output logic [31:0]               stall_cnt_o
);

    logic [NUM_SRC-1:0][REG_AW-1:0] issSrc, exSrc;
    logic [NUM_SRC-1:0]             exUsed;
    logic [STAGES-1:0]              stValid, stWe, stLoad;
    logic [STAGES-1:0][REG_AW-1:0]  stDst;
    logic                           active;
    logic                           hazardRaw, hazard, busy, stall;
    logic [NUM_SRC-1:0]             srcFound;
    logic [NUM_SRC-1:0][SEL_W-1:0]  fwdSel;
    logic [31:0]                    stallCnt;

    assign issSrc = issue_src_i;

    // Only the youngest producer of each source counts; an older in-flight
    // load to the same register is shadowed by it.
    always_comb begin
        hazardRaw = 1'b0;
        srcFound  = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = 0; k < STAGES; k++) begin
                if (!srcFound[s] && issue_src_used_i[s] && stValid[k] && stWe[k] &&
                    stDst[k] == issSrc[s] && !(ZERO_REG_EN && issSrc[s] == '0)) begin
                    srcFound[s] = 1'b1;
                    if (stLoad[k] && (k + 1 < LOAD_READY))
                        hazardRaw = 1'b1;
                end
            end
        end
    end

    // Walking from the oldest stage down leaves the youngest match selected.
    always_comb begin
        fwdSel = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int j = STAGES - 1; j >= 1; j--) begin
                if (stValid[0] && exUsed[s] && stValid[j] && stWe[j] &&
                    stDst[j] == exSrc[s] && !(ZERO_REG_EN && exSrc[s] == '0))
                    fwdSel[s] = SEL_W'(j);
            end
        end
    end

    // Outputs stay quiet through reset and the first cycle after release.
    assign hazard      = active & issue_valid_i & hazardRaw;
    assign busy        = active & ex_busy_i;
    assign stall       = hazard | busy;
    assign stall_f_o   = stall;
    assign stall_d_o   = stall;
    assign flush_e_o   = hazard & ~busy;
    assign flush_d_o   = active & redirect_i & ~stall;
    assign fwd_sel_o   = fwdSel;
    assign stall_cnt_o = stallCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active   <= 1'b0;
            stallCnt <= '0;
            stValid  <= '0;
            stWe     <= '0;
            stLoad   <= '0;
            stDst    <= '0;
            exSrc    <= '0;
            exUsed   <= '0;
        end else begin
            active <= 1'b1;
            if (hazard && stallCnt != 32'hFFFF_FFFF)
                stallCnt <= stallCnt + 32'd1;

            for (int k = 2; k < STAGES; k++) begin
                stValid[k] <= stValid[k-1];
                stWe[k]    <= stWe[k-1];
                stLoad[k]  <= stLoad[k-1];
                stDst[k]   <= stDst[k-1];
            end

            if (busy) begin
                // Multi-cycle op keeps stage 0; the slot behind it empties.
                stValid[1] <= 1'b0;
            end else begin
                stValid[1] <= stValid[0];
                stWe[1]    <= stWe[0];
                stLoad[1]  <= stLoad[0];
                stDst[1]   <= stDst[0];
                stValid[0] <= issue_valid_i & ~hazard;
                if (issue_valid_i && !hazard) begin
                    stWe[0]   <= issue_we_i;
                    stLoad[0] <= issue_load_i;
                    stDst[0]  <= issue_dst_i;
                    exSrc     <= issSrc;
                    exUsed    <= issue_src_used_i;
                end
            end
        end
    end

endmodule
